fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_STEP, default 2, SHALL be the byte increment added to the fetched address to form pc_next.
REQ-002 Parameter MAX_WAIT, default 15, SHALL be the number of REQ cycles without mem_ack before a fetch error is declared (range 1..255).
REQ-003 clock  input  1  SHALL be the single clock; all state updates on posedge clock.
REQ-004 reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 start  input  1  SHALL be the fetch request from the control unit, sampled on posedge.
REQ-006 flush  input  1  SHALL abort an outstanding fetch (taken branch/jump).
REQ-007 pc_in  input  16  SHALL be the current program counter value to fetch from.
REQ-008 mem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 mem_addr  output  16  SHALL be the registered fetch address.
REQ-010 mem_ack  input  1  SHALL indicate mem_rdata is valid this cycle.
REQ-011 mem_rdata  input  16  SHALL be the instruction word returned by memory.
REQ-012 instr  output  16  SHALL be the registered fetched instruction (instruction register).
REQ-013 pc_next  output  16  SHALL be the registered mem_addr + PC_STEP, for the PC write path.
REQ-014 fetch_done  output  1  SHALL pulse one cycle when instr/pc_next are updated.
REQ-015 busy  output  1  SHALL be high in REQ state.
REQ-016 fetch_err  output  1  SHALL be high in ERR state.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE, ERR; outputs registered, Moore-style.
REQ-018 IDLE/DONE/ERR + start=1 (flush=0) SHALL capture pc_in into mem_addr, clear the wait counter, and enter REQ next cycle (mem_req high one cycle after start).
REQ-019 REQ SHALL hold mem_req=1 and mem_addr stable until mem_ack, flush, or timeout.
REQ-020 REQ + mem_ack=1 SHALL load instr<=mem_rdata, pc_next<=mem_addr+PC_STEP, enter DONE; fetch_done=1 for exactly the DONE cycle.
REQ-021 pc_next arithmetic SHALL be 16-bit modulo (0xFFFE+2 = 0x0000), no carry-out.
REQ-022 DONE with start=0 SHALL return to IDLE; DONE with start=1 SHALL enter REQ (back-to-back fetch, no idle bubble).
REQ-023 Wait counter SHALL increment each REQ cycle without mem_ack; reaching MAX_WAIT SHALL enter ERR with mem_req=0.
REQ-024 mem_ack in the cycle the counter reaches MAX_WAIT SHALL win: normal completion, no error.
REQ-025 flush=1 in REQ SHALL return to IDLE next cycle, drop mem_req, leave instr/pc_next unchanged, no fetch_done; flush and mem_ack together SHALL behave as flush.
REQ-026 flush=1 with start=1 in any state SHALL take flush: no new fetch starts.
REQ-027 ERR SHALL hold fetch_err=1 until start (restart) or reset; flush in ERR SHALL return to IDLE.
REQ-028 start while in REQ SHALL be ignored; mem_ack outside REQ SHALL be ignored.

Reset
REQ-029 reset=1 SHALL force IDLE, mem_req=0, mem_addr=0x0000, instr=0x0000, pc_next=0x0000, fetch_done=0, busy=0, fetch_err=0, wait counter=0, overriding all inputs including mid-fetch.

Structure
REQ-030 State enum and WORD_W=16 SHALL live in shared package cpu_pkg; PC_STEP/MAX_WAIT SHALL remain module parameters.
REQ-031 The wait counter SHALL be one sub-module, fetch_wait_timer (clear, enable, expired), 8-bit.

Verification
REQ-032 Reset, pc_in=0x0040, start pulse, mem_ack after 3 REQ cycles with mem_rdata=0xA5C3 -> instr=0xA5C3, pc_next=0x0042, one-cycle fetch_done, busy high exactly 3+1 cycles.
REQ-033 pc_in=0xFFFE, immediate ack, rdata=0x1234 -> pc_next=0x0000, instr=0x1234.
REQ-034 start held high across DONE with pc_in=0x0010 then 0x0012 -> two fetches, REQ re-entered directly from DONE, mem_addr 0x0010 then 0x0012.
REQ-035 flush asserted with mem_ack in second REQ cycle, rdata=0xBEEF -> instr unchanged, no fetch_done, IDLE next cycle.
REQ-036 MAX_WAIT=4, no ack -> fetch_err high after 4 REQ cycles, mem_req low; repeat with ack on 4th cycle -> completion, fetch_err stays 0.
REQ-037 reset asserted in REQ cycle 2 -> all outputs at reset values next cycle, later mem_ack ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width and fetch FSM state encoding
package cpu_pkg;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} fetch_state_t;
endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: 8-bit count of unacknowledged request cycles
module fetch_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [7:0] LAST = 8'(LIMIT - 1);
  logic [7:0] r_count;
  always_ff @(posedge i_clock)
    if (i_reset || i_clear) r_count <= '0;
    else if (i_enable) r_count <= r_count + 8'd1;
  // high in the cycle whose missing ack would make the count reach LIMIT
  assign o_expired = r_count == LAST;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with wait timeout, flush and registered IR/pc_next
module fetch_unit import cpu_pkg::*; #(
  parameter int PC_STEP  = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic [WORD_W-1:0] i_pc_in,
  output logic              o_mem_req,
  output logic [WORD_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_pc_next,
  output logic              o_fetch_done,
  output logic              o_busy,
  output logic              o_fetch_err
);
  localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);
  fetch_state_t r_state, w_next;
  logic [WORD_W-1:0] r_mem_addr, r_instr, r_pc_next;
  logic w_in_req, w_launch, w_ack, w_expired;
  fetch_wait_timer #(.LIMIT(MAX_WAIT)) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_launch),
    .i_enable (w_in_req && !i_mem_ack && !i_flush),
    .o_expired(w_expired)
  );
  always_ff @(posedge i_clock)
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  // flush dominates start and ack everywhere; ack beats timeout
  always_comb begin
    w_in_req = r_state == S_REQ;
    w_launch = !w_in_req && i_start && !i_flush;
    w_ack    = w_in_req && i_mem_ack && !i_flush;
    w_next   = i_flush ? S_IDLE
             : w_in_req ? (i_mem_ack ? S_DONE : w_expired ? S_ERR : S_REQ)
             : i_start ? S_REQ
             : r_state == S_ERR ? S_ERR : S_IDLE;
  end
  always_ff @(posedge i_clock)
    if (i_reset) begin
      r_mem_addr <= '0;
      r_instr    <= '0;
      r_pc_next  <= '0;
    end else begin
      if (w_launch) r_mem_addr <= i_pc_in;
      if (w_ack) begin
        r_instr   <= i_mem_rdata;
        r_pc_next <= r_mem_addr + STEP;
      end
    end
  always_comb begin
    o_mem_req    = r_state == S_REQ;
    o_busy       = r_state == S_REQ;
    o_fetch_done = r_state == S_DONE;
    o_fetch_err  = r_state == S_ERR;
    o_mem_addr   = r_mem_addr;
    o_instr      = r_instr;
    o_pc_next    = r_pc_next;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for fetch_unit (MAX_WAIT=4)
module tb_fetch_unit;
  logic        i_clock = 0, i_reset = 0, i_start = 0, i_flush = 0, i_mem_ack = 0;
  logic [15:0] i_pc_in = 0, i_mem_rdata = 0;
  logic        o_mem_req, o_fetch_done, o_busy, o_fetch_err;
  logic [15:0] o_mem_addr, o_instr, o_pc_next;
  int n_cmp = 0, n_bad = 0;

  fetch_unit #(.PC_STEP(2), .MAX_WAIT(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_flush(i_flush),
    .i_pc_in(i_pc_in), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_instr(o_instr),
    .o_pc_next(o_pc_next), .o_fetch_done(o_fetch_done), .o_busy(o_busy),
    .o_fetch_err(o_fetch_err)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic rst, st, fl, ack;
    logic [15:0] pc, rd;
    logic req;
    logic [15:0] addr, ins, pcn;
    logic dn, bsy, er;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic rst, st, fl, ack, input logic [15:0] pc, rd);
    i_reset = rst; i_start = st; i_flush = fl; i_mem_ack = ack; i_pc_in = pc; i_mem_rdata = rd;
  endtask

  initial begin
    int busy_cnt, done_cnt;
    //              rst st fl ack pc       rd        req addr     ins      pcn      dn bsy er
    tv.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 16'hFFFE, 16'h0000, 1, 16'hFFFE, 16'h0000, 16'h0000, 0, 1, 0});
    tv.push_back('{0, 0, 0, 1, 16'h0000, 16'h1234, 0, 16'hFFFE, 16'h1234, 16'h0000, 1, 0, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFE, 16'h1234, 16'h0000, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 16'h0010, 16'h0000, 1, 16'h0010, 16'h1234, 16'h0000, 0, 1, 0});
    tv.push_back('{0, 1, 0, 1, 16'h0012, 16'h1111, 0, 16'h0010, 16'h1111, 16'h0012, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 16'h0012, 16'h0000, 1, 16'h0012, 16'h1111, 16'h0012, 0, 1, 0});
    tv.push_back('{0, 0, 0, 1, 16'h0000, 16'h2222, 0, 16'h0012, 16'h2222, 16'h0014, 1, 0, 0});
    tv.push_back('{0, 0, 0, 1, 16'h0000, 16'h3333, 0, 16'h0012, 16'h2222, 16'h0014, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 16'h0100, 16'h0000, 1, 16'h0100, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0100, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 1, 1, 16'h0000, 16'hBEEF, 0, 16'h0100, 16'h2222, 16'h0014, 0, 0, 0});
    tv.push_back('{0, 1, 1, 0, 16'h0200, 16'h0000, 0, 16'h0100, 16'h2222, 16'h0014, 0, 0, 0});
    tv.push_back('{0, 1, 0, 0, 16'h0300, 16'h0000, 1, 16'h0300, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0300, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0300, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0300, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0300, 16'h2222, 16'h0014, 0, 0, 1});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0300, 16'h2222, 16'h0014, 0, 0, 1});
    tv.push_back('{0, 0, 0, 1, 16'h0000, 16'h5555, 0, 16'h0300, 16'h2222, 16'h0014, 0, 0, 1});
    tv.push_back('{0, 1, 0, 0, 16'h0400, 16'h0000, 1, 16'h0400, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0400, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0400, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0400, 16'h2222, 16'h0014, 0, 1, 0});
    tv.push_back('{0, 0, 0, 1, 16'h0000, 16'h6789, 0, 16'h0400, 16'h6789, 16'h0402, 1, 0, 0});
    tv.push_back('{0, 1, 0, 0, 16'h0500, 16'h0000, 1, 16'h0500, 16'h6789, 16'h0402, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0500, 16'h6789, 16'h0402, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0500, 16'h6789, 16'h0402, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0500, 16'h6789, 16'h0402, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0500, 16'h6789, 16'h0402, 0, 0, 1});
    tv.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0500, 16'h6789, 16'h0402, 0, 0, 0});

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].st, tv[i].fl, tv[i].ack, tv[i].pc, tv[i].rd);
      step();
      chk("mem_req",    i, 16'(o_mem_req),    16'(tv[i].req));
      chk("mem_addr",   i, o_mem_addr,        tv[i].addr);
      chk("instr",      i, o_instr,           tv[i].ins);
      chk("pc_next",    i, o_pc_next,         tv[i].pcn);
      chk("fetch_done", i, 16'(o_fetch_done), 16'(tv[i].dn));
      chk("busy",       i, 16'(o_busy),       16'(tv[i].bsy));
      chk("fetch_err",  i, 16'(o_fetch_err),  16'(tv[i].er));
    end

    // basic fetch: ack in the 4th REQ cycle, busy for 4 cycles, single done pulse
    drive(1, 0, 0, 0, 16'h0000, 16'h0000); step();
    drive(0, 1, 0, 0, 16'h0040, 16'h0000); step();
    busy_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, k == 4, 16'h0000, k == 4 ? 16'hA5C3 : 16'h0000);
      busy_cnt += int'(o_busy);
      step();
      done_cnt += int'(o_fetch_done);
    end
    chk("seq_busy_cycles", 100, 16'(busy_cnt), 16'd4);
    chk("seq_done_pulses", 100, 16'(done_cnt), 16'd1);
    chk("seq_instr",       100, o_instr,       16'hA5C3);
    chk("seq_pc_next",     100, o_pc_next,     16'h0042);
    chk("seq_err",         100, 16'(o_fetch_err), 16'd0);

    // reset in the second REQ cycle, then a stray ack
    drive(0, 1, 0, 0, 16'h0700, 16'h0000); step();
    drive(0, 0, 0, 0, 16'h0000, 16'h0000); step();
    chk("rst_pre_req", 200, 16'(o_mem_req), 16'd1);
    drive(1, 0, 0, 1, 16'h0000, 16'h7777); step();
    chk("rst_req",   201, 16'(o_mem_req),    16'd0);
    chk("rst_addr",  201, o_mem_addr,        16'h0000);
    chk("rst_instr", 201, o_instr,           16'h0000);
    chk("rst_pcn",   201, o_pc_next,         16'h0000);
    chk("rst_busy",  201, 16'(o_busy),       16'd0);
    chk("rst_done",  201, 16'(o_fetch_done), 16'd0);
    chk("rst_err",   201, 16'(o_fetch_err),  16'd0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 16'h0000, 16'h9999); step();
      done_cnt += int'(o_fetch_done) + int'(o_busy);
    end
    chk("post_rst_activity", 202, 16'(done_cnt), 16'd0);
    chk("post_rst_instr",    202, o_instr,       16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
